// File: rtl/music_pkg.sv
// Shared note constants, FSM state type and the pitch table (half-periods at a 100 kHz clock).
package music_pkg;

  localparam logic [5:0] NOTE_REST = 6'd0;
  localparam logic [5:0] NOTE_C3   = 6'd1;
  localparam logic [5:0] NOTE_A4   = 6'd22;
  localparam logic [5:0] NOTE_B6   = 6'd48;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PLAY = 2'd1,
    ST_GAP  = 2'd2
  } voice_state_e;

  // Chromatic C3..B6, round(100000 / (2 * f)); rest codes return 1 so the counter just idles.
  function automatic logic [8:0] half_period(input logic [5:0] code);
    case (code)
      6'd1:  half_period = 9'd382;
      6'd2:  half_period = 9'd361;
      6'd3:  half_period = 9'd341;
      6'd4:  half_period = 9'd321;
      6'd5:  half_period = 9'd303;
      6'd6:  half_period = 9'd286;
      6'd7:  half_period = 9'd270;
      6'd8:  half_period = 9'd255;
      6'd9:  half_period = 9'd241;
      6'd10: half_period = 9'd227;
      6'd11: half_period = 9'd215;
      6'd12: half_period = 9'd202;
      6'd13: half_period = 9'd191;
      6'd14: half_period = 9'd180;
      6'd15: half_period = 9'd170;
      6'd16: half_period = 9'd161;
      6'd17: half_period = 9'd152;
      6'd18: half_period = 9'd143;
      6'd19: half_period = 9'd135;
      6'd20: half_period = 9'd128;
      6'd21: half_period = 9'd120;
      6'd22: half_period = 9'd114;
      6'd23: half_period = 9'd107;
      6'd24: half_period = 9'd101;
      6'd25: half_period = 9'd96;
      6'd26: half_period = 9'd90;
      6'd27: half_period = 9'd85;
      6'd28: half_period = 9'd80;
      6'd29: half_period = 9'd76;
      6'd30: half_period = 9'd72;
      6'd31: half_period = 9'd68;
      6'd32: half_period = 9'd64;
      6'd33: half_period = 9'd60;
      6'd34: half_period = 9'd57;
      6'd35: half_period = 9'd54;
      6'd36: half_period = 9'd51;
      6'd37: half_period = 9'd48;
      6'd38: half_period = 9'd45;
      6'd39: half_period = 9'd43;
      6'd40: half_period = 9'd40;
      6'd41: half_period = 9'd38;
      6'd42: half_period = 9'd36;
      6'd43: half_period = 9'd34;
      6'd44: half_period = 9'd32;
      6'd45: half_period = 9'd30;
      6'd46: half_period = 9'd28;
      6'd47: half_period = 9'd27;
      6'd48: half_period = 9'd25;
      default: half_period = 9'd1;
    endcase
  endfunction

  function automatic logic is_rest(input logic [5:0] code);
    is_rest = (code == NOTE_REST) || (code > NOTE_B6);
  endfunction

endpackage

// File: rtl/ms_timer.sv
// Millisecond timer: prescaler over the latched T plus a remaining-ms down-counter.
// last_tick_o is high in the final cycle of the loaded interval; load wins over counting.
module ms_timer #(
  parameter int REM_W = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             latch_t_i,
  input  logic [15:0]      tpm_i,
  input  logic             load_i,
  input  logic [REM_W-1:0] load_ms_i,
  input  logic             en_i,
  output logic             last_tick_o
);

  logic [15:0]      t_q, t_d;
  logic [15:0]      presc_q, presc_d;
  logic [REM_W-1:0] rem_q, rem_d;
  logic             wrap;

  assign wrap        = (presc_q == t_q - 16'd1);
  assign last_tick_o = en_i && wrap && (rem_q == REM_W'(1));

  always_comb begin
    t_d     = t_q;
    presc_d = presc_q;
    rem_d   = rem_q;
    if (latch_t_i) begin
      t_d = (tpm_i == 16'd0) ? 16'd1 : tpm_i;
    end
    if (load_i) begin
      presc_d = 16'd0;
      rem_d   = load_ms_i;
    end else if (en_i) begin
      if (wrap) begin
        presc_d = 16'd0;
        rem_d   = rem_q - REM_W'(1);
      end else begin
        presc_d = presc_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      t_q     <= 16'd0;
      presc_q <= 16'd0;
      rem_q   <= '0;
    end else begin
      t_q     <= t_d;
      presc_q <= presc_d;
      rem_q   <= rem_d;
    end
  end

endmodule

// File: rtl/tone_sequencer_voice.sv
// One-voice note player: square wave for D ms, GAP_MS ms of silence, then a done pulse.
// Accepts the next command in the done cycle, so back-to-back notes have no idle gap.
module tone_sequencer_voice
  import music_pkg::*;
#(
  parameter int GAP_MS = 10,
  parameter int DUR_W  = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [15:0]      ticks_per_milli,
  input  logic             note_valid,
  input  logic [5:0]       note_code,
  input  logic [DUR_W-1:0] note_dur_ms,
  output logic             note_ready,
  output logic             sound,
  output logic             busy,
  output logic             done
);

  localparam int GAP_W = (GAP_MS > 0) ? $clog2(GAP_MS + 1) : 1;
  localparam int REM_W = (DUR_W > GAP_W) ? DUR_W : GAP_W;

  voice_state_e     state_q, state_d;
  logic [5:0]       code_q, code_d;
  logic [8:0]       half_q, half_d;
  logic             sound_q, sound_d;
  logic             done_q, done_d;

  logic             tmr_latch, tmr_load, tmr_en, tmr_last;
  logic [REM_W-1:0] tmr_ms;

  assign tmr_en = (state_q != ST_IDLE);

  ms_timer #(.REM_W(REM_W)) u_ms_timer (
    .clk        (clk),
    .rst        (rst),
    .latch_t_i  (tmr_latch),
    .tpm_i      (ticks_per_milli),
    .load_i     (tmr_load),
    .load_ms_i  (tmr_ms),
    .en_i       (tmr_en),
    .last_tick_o(tmr_last)
  );

  always_comb begin
    state_d   = state_q;
    code_d    = code_q;
    half_d    = half_q;
    sound_d   = sound_q;
    done_d    = 1'b0;
    tmr_latch = 1'b0;
    tmr_load  = 1'b0;
    tmr_ms    = '0;
    case (state_q)
      ST_IDLE: begin
        if (note_valid) begin
          code_d    = note_code;
          half_d    = half_period(note_code) - 9'd1;
          sound_d   = 1'b0;
          tmr_latch = 1'b1;
          tmr_load  = 1'b1;
          tmr_ms    = REM_W'(note_dur_ms);
          // A zero-length note completes immediately without PLAY or GAP.
          if (note_dur_ms == '0) done_d = 1'b1;
          else                   state_d = ST_PLAY;
        end
      end
      ST_PLAY: begin
        if (half_q == 9'd0) begin
          half_d = half_period(code_q) - 9'd1;
          if (!is_rest(code_q)) sound_d = ~sound_q;
        end else begin
          half_d = half_q - 9'd1;
        end
        if (tmr_last) begin
          sound_d = 1'b0;
          if (GAP_MS == 0) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end else begin
            state_d  = ST_GAP;
            tmr_load = 1'b1;
            tmr_ms   = REM_W'(GAP_MS);
          end
        end
      end
      ST_GAP: begin
        if (tmr_last) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      code_q  <= 6'd0;
      half_q  <= 9'd0;
      sound_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      code_q  <= code_d;
      half_q  <= half_d;
      sound_q <= sound_d;
      done_q  <= done_d;
    end
  end

  assign note_ready = (state_q == ST_IDLE);
  assign busy       = (state_q != ST_IDLE);
  assign sound      = sound_q;
  assign done       = done_q;

endmodule

// File: tb/tb_tone_sequencer_voice.sv
// Bench for tone_sequencer_voice: three instances (GAP_MS = 1, 10, 0) checked cycle by cycle against a timing/pitch model.
module tb_tone_sequencer_voice;
  import music_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        nv  [3];
  logic [5:0]  nc  [3];
  logic [11:0] nd  [3];
  logic [15:0] tpm [3];
  logic        rdy [3];
  logic        snd [3];
  logic        bsy [3];
  logic        dn  [3];

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    tone_sequencer_voice #(
      .GAP_MS((g == 0) ? 1 : ((g == 1) ? 10 : 0)),
      .DUR_W (12)
    ) dut (
      .clk            (clk),
      .rst            (rst),
      .ticks_per_milli(tpm[g]),
      .note_valid     (nv[g]),
      .note_code      (nc[g]),
      .note_dur_ms    (nd[g]),
      .note_ready     (rdy[g]),
      .sound          (snd[g]),
      .busy           (bsy[g]),
      .done           (dn[g])
    );
  end

  function automatic int gap_of(input int s);
    return (s == 0) ? 1 : ((s == 1) ? 10 : 0);
  endfunction

  // Equal-tempered pitch from A4 = 440 Hz; half-period in cycles of a 100 kHz clock.
  function automatic int half_ref(input int code);
    real f;
    f = 440.0 * (2.0 ** (real'(code - 22) / 12.0));
    return $rtoi(50000.0 / f + 0.5);
  endfunction

  function automatic bit rest_ref(input int code);
    return (code < 1) || (code > 48);
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Accepts one note on instance s in the current cycle, then checks every following cycle
  // up to the done cycle (or up to abort_k, leaving the note in flight).
  task automatic run_note(input int s, input int code, input int dur, input int t,
                          input bit hold, input int abort_k,
                          output int done_cyc, output int rises);
    int tt, ktot, last, h;
    bit bad, eb, er, ed, es;
    logic [3:0] obs, expv;
    logic prev;
    tt   = (t == 0) ? 1 : t;
    h    = half_ref(code);
    ktot = (dur == 0) ? 1 : (dur + gap_of(s)) * tt + 1;
    last = (abort_k != 0 && abort_k < ktot) ? abort_k : ktot;
    nv[s] = 1'b1; nc[s] = 6'(code); nd[s] = 12'(dur); tpm[s] = 16'(t);
    tests++;
    if (rdy[s] !== 1'b1) begin
      fails++;
      $display("FAIL accept_ready dut%0d code=%0d: note_ready=%b, need 1", s, code, rdy[s]);
    end
    tick;
    bad = 0; rises = 0; prev = 1'b0; done_cyc = -1;
    for (int k = 1; k <= last; k++) begin
      if (!hold) begin
        nv[s] = 1'b0; nc[s] = 6'($urandom); nd[s] = 12'($urandom); tpm[s] = 16'($urandom_range(0, 300));
      end
      eb = (dur != 0) && (k < ktot);
      er = !eb;
      ed = (k == ktot);
      es = (dur != 0) && (k <= dur * tt) && !rest_ref(code) && ((((k - 1) / h) % 2) != 0);
      expv = {eb, er, ed, es};
      obs  = {bsy[s], rdy[s], dn[s], snd[s]};
      if (!bad && obs !== expv) begin
        bad = 1;
        fails++;
        $display("FAIL trace dut%0d code=%0d dur=%0d T=%0d cycle %0d: {busy,ready,done,sound}=%b, need %b",
                 s, code, dur, t, k, obs, expv);
      end
      if (snd[s] === 1'b1 && prev === 1'b0) rises++;
      prev = snd[s];
      if (dn[s] === 1'b1) done_cyc = cyc;
      if (k == last) break;
      tick;
    end
    tests++;
  endtask

  task automatic test_reset;
    for (int i = 0; i < 4; i++) begin
      tick;
      for (int s = 0; s < 3; s++) begin
        tests++;
        if ({bsy[s], rdy[s], dn[s], snd[s]} !== 4'b0100) begin
          fails++;
          $display("FAIL reset_hold dut%0d cycle %0d: {busy,ready,done,sound}=%b, need 0100",
                   s, i, {bsy[s], rdy[s], dn[s], snd[s]});
        end
      end
    end
    rst = 1'b0;
    for (int s = 0; s < 3; s++) nv[s] = 1'b0;
    tick;
    for (int s = 0; s < 3; s++) begin
      tests++;
      if ({bsy[s], rdy[s], dn[s], snd[s]} !== 4'b0100) begin
        fails++;
        $display("FAIL reset_release dut%0d: {busy,ready,done,sound}=%b, need 0100",
                 s, {bsy[s], rdy[s], dn[s], snd[s]});
      end
    end
  endtask

  task automatic test_a4;
    int d0, d1, r;
    run_note(0, int'(NOTE_A4), 2, 4, 0, 0, d0, r);
    tests++;
    if (r != 0) begin
      fails++;
      $display("FAIL a4_short_rises: got %0d rising edges, need 0", r);
    end
    tick;
    d0 = cyc;
    run_note(0, int'(NOTE_A4), 100, 4, 0, 0, d1, r);
    tests++;
    if (d1 - d0 != 405) begin
      fails++;
      $display("FAIL a4_long_latency: done %0d cycles after accept, need 405", d1 - d0);
    end
    tests++;
    if (r != 2) begin
      fails++;
      $display("FAIL a4_long_rises: got %0d rising edges, need 2", r);
    end
  endtask

  task automatic test_b6;
    int d, r;
    run_note(1, int'(NOTE_B6), 3, 100, 0, 0, d, r);
    tests++;
    if (r != 6) begin
      fails++;
      $display("FAIL b6_periods: got %0d rising edges, need 6", r);
    end
  endtask

  task automatic test_gap0;
    int d, r;
    run_note(2, int'(NOTE_C3), 2, 3, 0, 0, d, r);
  endtask

  task automatic test_back_to_back;
    int d1, d2, r;
    run_note(0, int'(NOTE_C3), 1, 4, 1, 0, d1, r);
    run_note(0, int'(NOTE_REST), 1, 4, 0, 0, d2, r);
    tests++;
    if (d2 - d1 != 9) begin
      fails++;
      $display("FAIL b2b_spacing: done pulses %0d cycles apart, need 9", d2 - d1);
    end
    tests++;
    if (r != 0) begin
      fails++;
      $display("FAIL b2b_rest_sound: got %0d rising edges on rest, need 0", r);
    end
  endtask

  task automatic test_zero_dur;
    int d, r;
    tick;
    run_note(0, int'(NOTE_A4), 0, 4, 0, 0, d, r);
    tick;
    tests++;
    if ({bsy[0], dn[0], snd[0]} !== 3'b000) begin
      fails++;
      $display("FAIL zero_dur_after: {busy,done,sound}=%b, need 000", {bsy[0], dn[0], snd[0]});
    end
  endtask

  task automatic test_reset_mid;
    int d, r;
    run_note(0, int'(NOTE_B6), 3, 100, 0, 30, d, r);
    rst = 1'b1;
    tick;
    tests++;
    if ({bsy[0], rdy[0], dn[0], snd[0]} !== 4'b0100) begin
      fails++;
      $display("FAIL reset_mid: {busy,ready,done,sound}=%b, need 0100", {bsy[0], rdy[0], dn[0], snd[0]});
    end
    rst = 1'b0;
    tick;
    tests++;
    if ({bsy[0], rdy[0], dn[0], snd[0]} !== 4'b0100) begin
      fails++;
      $display("FAIL reset_mid_no_done: {busy,ready,done,sound}=%b, need 0100", {bsy[0], rdy[0], dn[0], snd[0]});
    end
    run_note(0, int'(NOTE_A4), 2, 4, 0, 0, d, r);
  endtask

  task automatic test_random;
    int s, code, dur, t, d, r;
    for (int i = 0; i < 30; i++) begin
      s    = $urandom_range(0, 2);
      code = $urandom_range(0, 63);
      dur  = $urandom_range(0, 6);
      t    = $urandom_range(0, 5);
      run_note(s, code, dur, t, 0, 0, d, r);
      if ($urandom_range(0, 1) == 1) tick;
    end
  endtask

  initial begin
    rst = 1'b1;
    for (int s = 0; s < 3; s++) begin
      nv[s] = 1'b1; nc[s] = 6'd22; nd[s] = 12'd5; tpm[s] = 16'd4;
    end
    test_reset;
    test_a4;
    test_b6;
    test_gap0;
    test_back_to_back;
    test_zero_dur;
    test_reset_mid;
    test_random;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/tone_sequencer_voice.md
Name: tone_sequencer_voice

Overview:
- Downstream stage of the note sequencer inside music_processor; sole driver of the speaker pin.
- Accepts one note command at a time over a valid/ready handshake.
- Plays a square wave at the note's pitch for the commanded number of milliseconds, then a fixed articulation gap of silence.
- Signals completion with a one-cycle pulse.

Parameters:
- GAP_MS, 10, silent gap after every note, in ms (0 = no gap)
- DUR_W, 12, width of the note duration field in ms

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- ticks_per_milli  in  16  clk cycles per millisecond; 0 is treated as 1
- note_valid  in  1  upstream has a note command
- note_code  in  6  0 = rest; 1..48 = chromatic C3..B6; 49..63 = rest
- note_dur_ms  in  DUR_W  note length in ms
- note_ready  out  1  block can accept a command
- sound  out  1  square-wave speaker drive
- busy  out  1  high in PLAY or GAP
- done  out  1  one-cycle pulse when a note (including its gap) completes

Behaviour:
- Clocking and reset: single clock domain, clk. Reset is synchronous and active-high on rst.
- Reset values: state=IDLE, sound=0, note_ready=1, busy=0, done=0, all counters 0.
- FSM states:
  - IDLE: note_ready=1.
  - PLAY: tone active.
  - GAP: sound forced 0.
- Acceptance: a command is accepted when note_valid && note_ready on a rising edge.
  - On that edge: latch note_code, note_dur_ms and ticks_per_milli (max(1, value)).
  - Load the half-period counter with HALF[code]-1; clear the ms prescaler.
  - Go to PLAY. note_ready drops the following cycle.
- Zero duration: note_dur_ms=0 is accepted, skips PLAY and GAP, returns to IDLE with done=1 on the next cycle.
- Tone generation:
  - In PLAY, the half-period counter decrements each cycle.
  - At 0 it reloads HALF[code]-1 and toggles sound.
  - sound is 0 in the first PLAY cycle.
  - Rest codes hold sound=0 for the whole note.
- Ms timing:
  - The prescaler counts 0..T-1, where T is the latched ticks_per_milli.
  - Each wrap decrements the remaining-ms counter.
  - PLAY lasts exactly D*T cycles (D = note_dur_ms). Then GAP for GAP_MS*T cycles, or straight to IDLE if GAP_MS=0.
- Completion:
  - On return to IDLE: done=1 for exactly one cycle, note_ready=1 the same cycle.
  - Total latency: accept at cycle 0 -> done at cycle 1+(D+GAP_MS)*T.
- Back-to-back: note_valid held high is accepted in the done cycle. The next note's PLAY starts the cycle after, with no extra idle.
- Live input changes: changing ticks_per_milli or note_* mid-note has no effect until the next acceptance.
- Reset mid-note: rst in PLAY or GAP returns to IDLE next cycle with sound=0, no done pulse.
- Widths:
  - Half-period counter: 9 bits.
  - Prescaler: 16 bits.
  - Remaining-ms counter: max(DUR_W, width of GAP_MS).
  - No wrap is possible within spec ranges.
- Pitch table: HALF[] holds half-periods in clk cycles at a 100 kHz clock.
  - Formula: round(100000/(2*f)).
  - C3 (code 1) = 382; A4 (code 22, 440 Hz) = 114; B6 (code 48) = 25.

Decomposition:
- Shared package music_pkg holds:
  - the note-code constants (NOTE_REST=0, NOTE_C3=1, NOTE_A4=22, NOTE_B6=48);
  - the 48-entry HALF table as a constant function half_period(code);
  - the FSM state enum.
- One natural sub-module: ms_timer. It holds the prescaler plus the remaining-ms down-counter, with load, count-done outputs, and the latched T.
- The FSM and tone counter stay in tone_sequencer_voice.

Test Plan:
- Reset with note_valid=1: outputs are sound=0, note_ready=1, busy=0, done=0 for all reset cycles. No acceptance occurs while rst=1.
- ticks_per_milli=4, GAP_MS=1, code 22, dur 2:
  - sound toggles every 114 cycles over 8 PLAY cycles, i.e. stays 0 throughout;
  - rerun with dur 100: 400 PLAY cycles with toggles at PLAY cycles 114, 228, 342;
  - done asserts at cycle 1+(100+1)*4 = 405.
- Code 48, T=100, dur 3: 300 PLAY cycles, sound period 50 cycles (6 full periods), then 1000 gap cycles at 0.
- Back-to-back, note_valid held high with codes 1 then 0 (rest), dur 1, T=4:
  - second acceptance occurs in the first note's done cycle;
  - the rest note holds sound=0;
  - two done pulses, 9 cycles apart.
- note_dur_ms=0: accepted, busy stays 0, done pulses on the next cycle, sound stays 0.
- rst asserted mid-PLAY: next cycle state=IDLE, sound=0, note_ready=1, no done pulse. A new note plays normally afterwards.
